// File: rtl/dino_pkg.sv
// Shared encodings and constants for the dinosaur runner game engine.
package dino_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [2:0] {
    ST_INI  = 3'b001,
    ST_PLAY = 3'b010,
    ST_DONE = 3'b100
  } game_state_e;

  // Galois form of x^8+x^6+x^5+x^4+1, shifting right
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/dino_lfsr8.sv
// 8-bit Galois LFSR that advances once per enabled cycle; drives obstacle spawn decisions.
module dino_lfsr8
  import dino_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] q
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/dino_game_core.sv
// Dinosaur runner engine: game FSM, jump physics, obstacle slots, collision and score.
// Optional build macro DINO_SPEEDUP_EN makes scroll speed grow with score.
//
//   state   | meaning
//   ST_INI  | idle, waiting for up to start a game
//   ST_PLAY | game running, physics advance on tick
//   ST_DONE | crashed, positions/score frozen until up
module dino_game_core
  import dino_pkg::*;
#(
  parameter int NUM_OBS   = 4,
  parameter int SCORE_W   = 16,
  parameter int SCREEN_W  = 640,
  parameter int GROUND_Y  = 515,
  parameter int DINO_X    = 200,
  parameter int DINO_SIZE = 50,
  parameter int OBS_W     = 20,
  parameter int OBS_H     = 40,
  parameter int JUMP_V0   = 12,
  parameter int GRAVITY   = 1,
  parameter int SPEED     = 4,
  parameter int SPAWN_GAP = 160
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       tick,
  input  logic                       up,
  output logic [2:0]                 state,
  output logic [COORD_W-1:0]         dino_y,
  output logic [NUM_OBS*COORD_W-1:0] obs_x,
  output logic [NUM_OBS-1:0]         obs_vld,
  output logic [SCORE_W-1:0]         score,
  output logic                       collide
);

  game_state_e          state_q, state_d;
  logic                 up_q;
  logic [COORD_W-1:0]   dino_y_q, dino_y_d;
  logic signed [7:0]    vy_q, vy_d;
  logic [COORD_W-1:0]   obs_x_q [NUM_OBS];
  logic [COORD_W-1:0]   obs_x_d [NUM_OBS];
  logic [NUM_OBS-1:0]   obs_vld_q, obs_vld_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 collide_q, collide_d;

  logic [7:0]           lfsr_q;
  logic                 up_evt;
  logic                 on_ground;
  logic                 dino_low;
  logic                 collision;
  logic                 spawn_ok;
  logic [COORD_W-1:0]   speed;
  logic [NUM_OBS-1:0]   hit, retire, near_edge, slot_free, spawn_sel;
  logic [SCORE_W-1:0]   score_inc;

  dino_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick),
    .q     (lfsr_q)
  );

  assign up_evt    = up & ~up_q;
  assign on_ground = (dino_y_q == COORD_W'(GROUND_Y)) && (vy_q == 8'sd0);
  assign dino_low  = dino_y_q > COORD_W'(GROUND_Y - OBS_H);

`ifdef DINO_SPEEDUP_EN
  logic [SCORE_W-1:0] boost;
  assign boost = score_q >> 4;
  always_comb begin
    if (32'(boost) >= SPEED) speed = COORD_W'(2 * SPEED);
    else                     speed = COORD_W'(SPEED + 32'(boost));
  end
`else
  assign speed = COORD_W'(SPEED);
`endif

  for (genvar g = 0; g < NUM_OBS; g++) begin : g_slot
    assign hit[g]       = obs_vld_q[g]
                          && (obs_x_q[g] <= COORD_W'(DINO_X + DINO_SIZE))
                          && (({1'b0, obs_x_q[g]} + (COORD_W+1)'(OBS_W)) >= (COORD_W+1)'(DINO_X));
    assign retire[g]    = obs_vld_q[g] && (obs_x_q[g] < (speed + COORD_W'(OBS_W)));
    assign near_edge[g] = obs_vld_q[g] && (obs_x_q[g] > COORD_W'(SCREEN_W - SPAWN_GAP));
    // a slot vacated on this tick may be refilled on the same tick
    assign slot_free[g] = ~obs_vld_q[g] | retire[g];
    assign obs_x[g*COORD_W +: COORD_W] = obs_x_q[g];
  end

  assign collision = (|hit) & dino_low;
  assign spawn_ok  = ((lfsr_q & 8'h03) == 8'h00) && (|slot_free) && !(|near_edge);

  always_comb begin
    logic found;
    found     = 1'b0;
    spawn_sel = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (slot_free[i] && !found) begin
        spawn_sel[i] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    score_inc = score_q;
    for (int i = 0; i < NUM_OBS; i++) begin
      if (retire[i] && (score_inc != '1)) score_inc = score_inc + SCORE_W'(1);
    end
  end

  always_comb begin
    logic signed [7:0]  vy_launch;
    logic signed [11:0] y_next;
    state_d   = state_q;
    dino_y_d  = dino_y_q;
    vy_d      = vy_q;
    obs_x_d   = obs_x_q;
    obs_vld_d = obs_vld_q;
    score_d   = score_q;
    collide_d = 1'b0;
    vy_launch = vy_q;
    y_next    = '0;
    case (state_q)
      ST_INI: begin
        if (up_evt) begin
          state_d   = ST_PLAY;
          score_d   = '0;
          obs_vld_d = '0;
          for (int i = 0; i < NUM_OBS; i++) obs_x_d[i] = '0;
          dino_y_d  = COORD_W'(GROUND_Y);
          vy_d      = '0;
        end
      end
      ST_PLAY: begin
        if (collision) begin
          state_d   = ST_DONE;
          collide_d = 1'b1;
        end else begin
          if (up_evt && on_ground) vy_launch = 8'(JUMP_V0);
          vy_d = vy_launch;
          if (tick) begin
            y_next = $signed({2'b00, dino_y_q}) - {{4{vy_launch[7]}}, vy_launch};
            vy_d   = vy_launch - 8'(GRAVITY);
            if (y_next >= $signed(12'(GROUND_Y))) begin
              dino_y_d = COORD_W'(GROUND_Y);
              vy_d     = '0;
            end else begin
              dino_y_d = y_next[COORD_W-1:0];
            end
            for (int i = 0; i < NUM_OBS; i++) begin
              if (spawn_ok && spawn_sel[i]) begin
                obs_vld_d[i] = 1'b1;
                obs_x_d[i]   = COORD_W'(SCREEN_W);
              end else if (retire[i]) begin
                obs_vld_d[i] = 1'b0;
              end else if (obs_vld_q[i]) begin
                obs_x_d[i] = obs_x_q[i] - speed;
              end
            end
            score_d = score_inc;
          end
        end
      end
      ST_DONE: begin
        if (up_evt) state_d = ST_INI;
      end
      default: state_d = ST_INI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INI;
      up_q      <= 1'b0;
      dino_y_q  <= COORD_W'(GROUND_Y);
      vy_q      <= '0;
      for (int i = 0; i < NUM_OBS; i++) obs_x_q[i] <= '0;
      obs_vld_q <= '0;
      score_q   <= '0;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      up_q      <= up;
      dino_y_q  <= dino_y_d;
      vy_q      <= vy_d;
      obs_x_q   <= obs_x_d;
      obs_vld_q <= obs_vld_d;
      score_q   <= score_d;
      collide_q <= collide_d;
    end
  end

  assign state   = state_q;
  assign dino_y  = dino_y_q;
  assign obs_vld = obs_vld_q;
  assign score   = score_q;
  assign collide = collide_q;

endmodule
